photo_sram_writer: RTL and testbench
====================================

# photo_sram_writer

Loads one photo into external SRAM in the packed pixel layout that the colour-transform engine reads back. It accepts a valid/ready stream of 24-bit RGB pixels, computes an 8-bit gray value, and writes each pixel as two 16-bit words into the photo slot selected at start. It sits between the pixel source (camera/UART capture) and the shared SRAM port, and is the write-side counterpart of the SRAM read path in the transform engine.

## Interface
- ADDR_W, 20, SRAM word-address width
- clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous reset, active-high
- i_start  input  1  one-cycle pulse; begins a photo load
- i_photo_sel  input  2  slot: 0 source, 1 target, 2 output; 3 invalid
- iCol_Max  input  10  columns per photo
- iRow_Max  input  10  rows per photo
- i_pix_valid  input  1  pixel present on i_pix
- i_pix  input  24  {R[23:16], G[15:8], B[7:0]}
- o_pix_ready  output  1  pixel accepted when valid & ready
- o_busy  output  1  load in progress
- o_done  output  1  one-cycle pulse after last word written
- oSRAM_WE_N  output  1  write enable, active-low
- oSRAM_OE_N  output  1  output enable, active-low; always 1 in this block
- oSRAM_ADDR  output  ADDR_W  word address
- oSRAM_DATA  inout  16  driven only while oSRAM_WE_N==0, else 16'bz

## Operation
- PHOTO_SIZE = iCol_Max*iRow_Max (32-bit); base = i_photo_sel*2*PHOTO_SIZE; both latched on accepted i_start.
- Pixel n (0-based) occupies base+2n = {R,G} and base+2n+1 = {B,gray}.
- gray = (77*R + 150*G + 29*B) >> 8, 16-bit intermediate, truncating; result 0..255.
- States: S_IDLE, S_WAIT, S_W_HI, S_W_LO, S_DONE.
- S_IDLE: o_busy=0, ready=0. i_start with sel≠3 and PHOTO_SIZE≠0 → S_WAIT, pixel counter=0. sel==3 → start ignored. PHOTO_SIZE==0 → S_DONE, no writes.
- S_WAIT: ready=1; on handshake register pixel and gray → S_W_HI.
- S_W_HI: WE_N=0, addr=base+2n, data={R,G} → S_W_LO.
- S_W_LO: WE_N=0, addr=base+2n+1, data={B,gray}. If n==PHOTO_SIZE-1 → S_DONE, ready=0. Else ready=1; handshake → register next pixel, n+1, S_W_HI; no handshake → n+1, S_WAIT.
- S_DONE: o_done=1 for one cycle → S_IDLE.
- i_start while o_busy=1 ignored. Pixels offered in S_IDLE/S_DONE never accepted (ready=0).
- iCol_Max/iRow_Max/i_photo_sel changes after start have no effect.

## Timing
- Reset values: o_pix_ready=0, o_busy=0, o_done=0, oSRAM_WE_N=1, oSRAM_OE_N=1, oSRAM_ADDR=0, oSRAM_DATA=z; state S_IDLE, counter 0.
- All SRAM outputs registered; WE_N, ADDR and data change together on the clock edge.
- Start→first handshake possible 1 cycle after start. Handshake→hi write next cycle, lo write cycle after.
- Sustained throughput: 1 pixel / 2 cycles (ready high during S_W_LO).
- Last lo write → o_done next cycle; o_busy high from cycle after start through S_DONE inclusive.
- Reset mid-load: immediate abort, WE_N=1 asynchronously, no o_done; partial photo remains in SRAM.

## Configuration
- GRAY_STORE_EN defined: low byte of word base+2n+1 = gray as above.
- Undefined: low byte written 8'h00; gray multipliers not instantiated; all else identical.

## Test plan
- 2x2, sel=1, pixels 0x123456 ×4 → writes addr 8..15 alternating 0x1234/0x562D (GRAY_STORE_EN), o_done once, 8 write cycles.
- 1x1, sel=0, pixel 0xFFFFFF → addr0=0xFFFF, addr1=0xFFFF; without GRAY_STORE_EN addr1=0xFF00.
- Valid held high, 4x1, sel=2 → ready pattern 1,0,1,0…, addresses 16..23 contiguous, 8 cycles from first handshake to last write.
- Valid toggled every third cycle → no address skipped or repeated, WE_N high in S_WAIT, data bus z.
- i_start with sel=3, and with iCol_Max=0 → no writes; first: o_busy stays 0; second: o_done pulse 1 cycle later.
- i_rst asserted after 3rd pixel of 4x4 → all outputs to reset values same cycle, no o_done; new start loads correctly from base.

Source files
------------

// File: rtl/photo_sram_writer_if.sv
// Load-control, pixel-stream and SRAM command signals of photo_sram_writer.
// The bidirectional SRAM data bus stays a plain inout port on the writer.
interface photo_sram_writer_if #(
  parameter int ADDR_W = 20
);
  logic              i_start;
  logic [1:0]        i_photo_sel;
  logic [9:0]        iCol_Max;
  logic [9:0]        iRow_Max;
  logic              i_pix_valid;
  logic [23:0]       i_pix;
  logic              o_pix_ready;
  logic              o_busy;
  logic              o_done;
  logic              oSRAM_WE_N;
  logic              oSRAM_OE_N;
  logic [ADDR_W-1:0] oSRAM_ADDR;

  modport master (
    output i_start, i_photo_sel, iCol_Max, iRow_Max, i_pix_valid, i_pix,
    input  o_pix_ready, o_busy, o_done, oSRAM_WE_N, oSRAM_OE_N, oSRAM_ADDR
  );

  modport slave (
    input  i_start, i_photo_sel, iCol_Max, iRow_Max, i_pix_valid, i_pix,
    output o_pix_ready, o_busy, o_done, oSRAM_WE_N, oSRAM_OE_N, oSRAM_ADDR
  );
endinterface

// File: rtl/photo_sram_writer.sv
// Streams RGB pixels into an SRAM photo slot as {R,G},{B,gray} word pairs.
// Define GRAY_STORE_EN to store the gray byte; otherwise that byte is written as 0.
module photo_sram_writer #(
  parameter int ADDR_W = 20
) (
  input  logic               clk,
  input  logic               i_rst,
  photo_sram_writer_if.slave bus,
  inout  wire  [15:0]        oSRAM_DATA
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_W_HI, S_W_LO, S_DONE} state_t;

  state_t            state;
  logic [31:0]       pix_cnt;
  logic [31:0]       last_idx;
  logic [ADDR_W-1:0] addr_ptr;
  logic [15:0]       lo_word;
  logic [15:0]       data_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              pix_ready;
  logic              busy;
  logic              done;
  logic              we_n;

  logic [31:0]       size_calc;
  logic              handshake;
  logic [15:0]       hi_in;
  logic [15:0]       lo_in;

  assign size_calc = 32'(bus.iCol_Max) * 32'(bus.iRow_Max);
  assign handshake = pix_ready & bus.i_pix_valid;
  assign hi_in     = bus.i_pix[23:8];

`ifdef GRAY_STORE_EN
  // Weights sum to 256, so the 16-bit sum cannot overflow and >>8 yields 0..255.
  logic [7:0] gray;
  assign gray  = 8'((16'd77  * {8'd0, bus.i_pix[23:16]} +
                     16'd150 * {8'd0, bus.i_pix[15:8]}  +
                     16'd29  * {8'd0, bus.i_pix[7:0]}) >> 8);
  assign lo_in = {bus.i_pix[7:0], gray};
`else
  assign lo_in = {bus.i_pix[7:0], 8'h00};
`endif

  // addr_ptr always holds base+2n for the pixel currently being written.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      pix_cnt   <= '0;
      last_idx  <= '0;
      addr_ptr  <= '0;
      lo_word   <= '0;
      data_reg  <= '0;
      addr_reg  <= '0;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      we_n      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          pix_ready <= 1'b0;
          busy      <= 1'b0;
          we_n      <= 1'b1;
          if (bus.i_start && bus.i_photo_sel != 2'd3) begin
            busy     <= 1'b1;
            pix_cnt  <= '0;
            last_idx <= size_calc - 32'd1;
            addr_ptr <= ADDR_W'(32'(bus.i_photo_sel) * (size_calc << 1));
            if (size_calc == 32'd0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              pix_ready <= 1'b1;
              state     <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (handshake) begin
            lo_word   <= lo_in;
            data_reg  <= hi_in;
            addr_reg  <= addr_ptr;
            we_n      <= 1'b0;
            pix_ready <= 1'b0;
            state     <= S_W_HI;
          end
        end

        S_W_HI: begin
          addr_reg  <= addr_ptr + ADDR_W'(1);
          data_reg  <= lo_word;
          pix_ready <= (pix_cnt != last_idx);
          state     <= S_W_LO;
        end

        // Accepting the next pixel here keeps a back-to-back stream at 2 cycles/pixel.
        S_W_LO: begin
          if (pix_cnt == last_idx) begin
            we_n      <= 1'b1;
            pix_ready <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            pix_cnt  <= pix_cnt + 32'd1;
            addr_ptr <= addr_ptr + ADDR_W'(2);
            if (handshake) begin
              lo_word   <= lo_in;
              data_reg  <= hi_in;
              addr_reg  <= addr_ptr + ADDR_W'(2);
              pix_ready <= 1'b0;
              state     <= S_W_HI;
            end else begin
              we_n      <= 1'b1;
              pix_ready <= 1'b1;
              state     <= S_WAIT;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_pix_ready = pix_ready;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;
  assign bus.oSRAM_WE_N  = we_n;
  assign bus.oSRAM_OE_N  = 1'b1;
  assign bus.oSRAM_ADDR  = addr_reg;
  assign oSRAM_DATA      = we_n ? 16'bz : data_reg;

endmodule

// File: tb/tb_photo_sram_writer.sv
// Directed, table-driven bench for photo_sram_writer: whole-photo loads are
// replayed from a vector table, then multi-cycle corner cases run by hand.
module tb_photo_sram_writer;

  localparam int ADDR_W = 20;

  logic       clk = 1'b0;
  logic       i_rst;
  wire [15:0] sram_data;

  photo_sram_writer_if #(.ADDR_W(ADDR_W)) bus ();

  photo_sram_writer #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .bus        (bus),
    .oSRAM_DATA (sram_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  cols;
    logic [9:0]  rows;
    logic [1:0]  sel;
    logic [23:0] pix;
    int          exp_base;
    logic [15:0] exp_hi;
    logic [15:0] exp_lo_gray;
    logic [15:0] exp_lo_plain;
  } vec_t;

  vec_t vecs[5];

  int checks   = 0;
  int failures = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [15:0] exp_hi_q[$];
  logic [15:0] exp_lo_q[$];
  bit          ready_log[$];
  int          done_cnt;
  int          done_cyc;
  int          oe_low;
  int          accepted;
  bit          timed_out;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] lo_of(input logic [23:0] p);
    logic [15:0] s;
    s = 16'd77 * {8'd0, p[23:16]} + 16'd150 * {8'd0, p[15:8]} + 16'd29 * {8'd0, p[7:0]};
`ifdef GRAY_STORE_EN
    return {p[7:0], s[15:8]};
`else
    return {p[7:0], 8'h00 & s[7:0]};
`endif
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  // Runs one load and logs every write; returns at a negedge a few cycles after o_done.
  task automatic apply_stimulus(input logic [9:0] cols, input logic [9:0] rows,
                                input logic [1:0] sel, input logic [23:0] pix0,
                                input logic [23:0] step, input bit toggle);
    int post;
    wr_addr.delete();
    wr_data.delete();
    ready_log.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    oe_low    = 0;
    accepted  = 0;
    post      = 0;
    timed_out = 1'b1;
    bus.iCol_Max    = cols;
    bus.iRow_Max    = rows;
    bus.i_photo_sel = sel;
    bus.i_pix_valid = 1'b1;
    bus.i_pix       = pix0;
    pulse_start();
    bus.iCol_Max    = 10'd7;
    bus.iRow_Max    = 10'd9;
    bus.i_photo_sel = 2'd3;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      ready_log.push_back(bus.o_pix_ready);
      if (!bus.oSRAM_OE_N) oe_low++;
      if (!bus.oSRAM_WE_N) begin
        wr_addr.push_back(32'(bus.oSRAM_ADDR));
        wr_data.push_back(32'(sram_data));
      end
      if (bus.o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        timed_out = 1'b0;
      end
      if (!timed_out) begin
        post++;
        if (post > 4) break;
      end
      if (toggle) bus.i_pix_valid = ((cyc / 3) % 2) == 0;
      bus.i_pix = pix0 + 24'(accepted) * step;
      if (bus.i_pix_valid && bus.o_pix_ready) accepted++;
    end
  endtask

  task automatic verify_load(input string tag, input int base);
    int n;
    n = exp_hi_q.size();
    check_output({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check_output({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check_output({tag, "_write_count"}, 32'(wr_addr.size()), 32'(2 * n));
    check_output({tag, "_oe_low"}, 32'(oe_low), 32'd0);
    for (int k = 0; k < 2 * n && k < wr_addr.size(); k++) begin
      check_output($sformatf("%s_addr%0d", tag, k), wr_addr[k], 32'(base + k));
      check_output($sformatf("%s_data%0d", tag, k), wr_data[k],
                   32'((k % 2 == 0) ? exp_hi_q[k / 2] : exp_lo_q[k / 2]));
    end
    check_output({tag, "_busy_after"}, 32'(bus.o_busy), 32'd0);
    check_output({tag, "_ready_idle"}, 32'(bus.o_pix_ready), 32'd0);
  endtask

  task automatic run_vector(input int i);
    int npix;
    npix = int'(vecs[i].cols) * int'(vecs[i].rows);
    apply_stimulus(vecs[i].cols, vecs[i].rows, vecs[i].sel, vecs[i].pix, 24'd0, 1'b0);
    exp_hi_q.delete();
    exp_lo_q.delete();
    for (int k = 0; k < npix; k++) begin
      exp_hi_q.push_back(vecs[i].exp_hi);
`ifdef GRAY_STORE_EN
      exp_lo_q.push_back(vecs[i].exp_lo_gray);
`else
      exp_lo_q.push_back(vecs[i].exp_lo_plain);
`endif
    end
    verify_load($sformatf("vec%0d", i), vecs[i].exp_base);
    bus.i_pix_valid = 1'b0;
  endtask

  initial begin
    int hits_busy, hits_we, hits_done, hits_rdy;
    bit pattern[9];

    vecs[0] = '{10'd2, 10'd2, 2'd1, 24'h123456,  8, 16'h1234, 16'h562D, 16'h5600};
    vecs[1] = '{10'd1, 10'd1, 2'd0, 24'hFFFFFF,  0, 16'hFFFF, 16'hFFFF, 16'hFF00};
    vecs[2] = '{10'd4, 10'd1, 2'd2, 24'h00FF00, 16, 16'h00FF, 16'h0095, 16'h0000};
    vecs[3] = '{10'd3, 10'd1, 2'd1, 24'hFF0000,  6, 16'hFF00, 16'h004C, 16'h0000};
    vecs[4] = '{10'd1, 10'd2, 2'd2, 24'h0000FF,  8, 16'h0000, 16'hFF1C, 16'hFF00};

    i_rst           = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_photo_sel = 2'd0;
    bus.iCol_Max    = 10'd0;
    bus.iRow_Max    = 10'd0;
    bus.i_pix_valid = 1'b0;
    bus.i_pix       = 24'd0;
    #1;
    check_output("rst_we_n",  32'(bus.oSRAM_WE_N),  32'd1);
    check_output("rst_oe_n",  32'(bus.oSRAM_OE_N),  32'd1);
    check_output("rst_ready", 32'(bus.o_pix_ready), 32'd0);
    check_output("rst_busy",  32'(bus.o_busy),      32'd0);
    check_output("rst_done",  32'(bus.o_done),      32'd0);
    check_output("rst_addr",  32'(bus.oSRAM_ADDR),  32'd0);
    repeat (3) @(negedge clk);
    i_rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vector(i);

    // Valid held high: ready alternates and the last lo write carries ready low.
    pattern = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    apply_stimulus(10'd4, 10'd1, 2'd2, 24'h00FF00, 24'd0, 1'b0);
    bus.i_pix_valid = 1'b0;
    for (int k = 0; k < 9 && k < ready_log.size(); k++)
      check_output($sformatf("ready_pattern%0d", k), 32'(ready_log[k]), 32'(pattern[k]));
    check_output("stream_done_cycle", 32'(done_cyc), 32'd9);
    check_output("stream_writes", 32'(wr_addr.size()), 32'd8);

    // Gappy source with distinct pixels: addresses stay contiguous, data tracks pixel order.
    apply_stimulus(10'd3, 10'd2, 2'd1, 24'h102030, 24'h030507, 1'b1);
    exp_hi_q.delete();
    exp_lo_q.delete();
    for (int k = 0; k < 6; k++) begin
      logic [23:0] p;
      p = 24'h102030 + 24'(k) * 24'h030507;
      exp_hi_q.push_back(p[23:8]);
      exp_lo_q.push_back(lo_of(p));
    end
    verify_load("toggle", 12);
    bus.i_pix_valid = 1'b0;

    // Invalid slot: start ignored entirely.
    bus.iCol_Max    = 10'd2;
    bus.iRow_Max    = 10'd2;
    bus.i_photo_sel = 2'd3;
    bus.i_pix_valid = 1'b1;
    pulse_start();
    hits_busy = 0; hits_we = 0; hits_done = 0; hits_rdy = 0;
    repeat (6) begin
      if (bus.o_busy)       hits_busy++;
      if (!bus.oSRAM_WE_N)  hits_we++;
      if (bus.o_done)       hits_done++;
      if (bus.o_pix_ready)  hits_rdy++;
      @(negedge clk);
    end
    check_output("sel3_busy",  32'(hits_busy), 32'd0);
    check_output("sel3_we",    32'(hits_we),   32'd0);
    check_output("sel3_done",  32'(hits_done), 32'd0);
    check_output("sel3_ready", 32'(hits_rdy),  32'd0);

    // Empty photo: straight to done, no writes.
    bus.iCol_Max    = 10'd0;
    bus.iRow_Max    = 10'd5;
    bus.i_photo_sel = 2'd1;
    pulse_start();
    check_output("zero_done_s0", 32'(bus.o_done), 32'd1);
    check_output("zero_busy_s0", 32'(bus.o_busy), 32'd1);
    check_output("zero_we_s0",   32'(bus.oSRAM_WE_N), 32'd1);
    @(negedge clk);
    check_output("zero_done_s1", 32'(bus.o_done), 32'd0);
    check_output("zero_busy_s1", 32'(bus.o_busy), 32'd0);
    bus.i_pix_valid = 1'b0;

    // Reset during the third pixel of a 4x4 load.
    bus.iCol_Max    = 10'd4;
    bus.iRow_Max    = 10'd4;
    bus.i_photo_sel = 2'd0;
    bus.i_pix       = 24'h123456;
    bus.i_pix_valid = 1'b1;
    pulse_start();
    accepted = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (bus.i_pix_valid && bus.o_pix_ready) accepted++;
      if (accepted == 3) break;
      @(negedge clk);
    end
    check_output("abort_accepted", 32'(accepted), 32'd3);
    @(posedge clk);
    #2;
    check_output("abort_we_before", 32'(bus.oSRAM_WE_N), 32'd0);
    check_output("abort_addr_before", 32'(bus.oSRAM_ADDR), 32'd4);
    i_rst = 1'b1;
    #1;
    check_output("abort_we_n",  32'(bus.oSRAM_WE_N),  32'd1);
    check_output("abort_busy",  32'(bus.o_busy),      32'd0);
    check_output("abort_ready", 32'(bus.o_pix_ready), 32'd0);
    check_output("abort_done",  32'(bus.o_done),      32'd0);
    check_output("abort_addr",  32'(bus.oSRAM_ADDR),  32'd0);
    hits_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_done) hits_done++;
    end
    i_rst = 1'b0;
    bus.i_pix_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_done) hits_done++;
    end
    check_output("abort_no_done", 32'(hits_done), 32'd0);
    run_vector(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule
